// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator: sync polarity encodings,
// the output pipeline depth limit, and a helper mapping "sync asserted" to
// the pin level for a given polarity.
package vga_timing_pkg;

  // Polarity encodings for the HS_ACTIVE_HIGH / VS_ACTIVE_HIGH parameters.
  localparam logic POL_ACTIVE_LOW  = 1'b0;
  localparam logic POL_ACTIVE_HIGH = 1'b1;

  // Deepest extra output pipeline supported (OUT_DELAY range is 0..this).
  localparam int OUT_DELAY_MAX = 7;

  // Pin level for a sync signal: the polarity level when asserted, its
  // complement otherwise.
  function automatic logic sync_level(input logic asserted, input logic active_high);
    return asserted ? active_high : ~active_high;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One timing axis (horizontal or vertical): a wrapping counter over
// active + front porch + sync + back porch, plus window decode of the
// current count. The same block serves both axes; the vertical instance
// advances on the horizontal carry.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 1920,
  parameter int FP     = 88,
  parameter int SYNC   = 44,
  parameter int BP     = 148,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_i,     // advance the counter this cycle
  output logic [CNT_W-1:0] cnt_o,     // current count
  output logic             carry_o,   // advancing out of the last count
  output logic             sync_o,    // count inside the sync window (unpolarised)
  output logic             active_o,  // count inside the visible region
  output logic             first_o    // count is zero
);

  localparam int TOT = ACTIVE + FP + SYNC + BP;

  // A total that does not fit the counter would silently alias; refuse it.
  if (TOT > (2 ** CNT_W)) begin : g_bad_total
    $fatal(1, "timing_axis: total %0d does not fit in %0d bits", TOT, CNT_W);
  end

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOT - 1);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last;

  assign last = (cnt_q == LAST);

  // Next count: hold unless advancing, wrap to zero after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      cnt_d = last ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  // Counter register, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign carry_o  = adv_i & last;
  assign sync_o   = (cnt_q >= SYNC_START) && (cnt_q <= SYNC_END);
  assign active_o = (cnt_q < ACT_END);
  assign first_o  = (cnt_q == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/video timing generator. Two timing_axis instances (horizontal and
// vertical) produce the raster position; a decode stage plus OUT_DELAY
// extra stages register every output so that downstream pixel fetch
// latency can be absorbed. All stages advance only on pix_ce.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE       = 1920,
  parameter int H_FP           = 88,
  parameter int H_SYNC         = 44,
  parameter int H_BP           = 148,
  parameter int V_ACTIVE       = 1080,
  parameter int V_FP           = 4,
  parameter int V_SYNC         = 5,
  parameter int V_BP           = 36,
  parameter int HS_ACTIVE_HIGH = 0,
  parameter int VS_ACTIVE_HIGH = 0,
  parameter int CNT_W          = 12,
  parameter int OUT_DELAY      = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_enable,
  output logic [CNT_W-1:0] x_idx,
  output logic [CNT_W-1:0] y_idx,
  output logic             line_start,
  output logic             frame_start
);

  if ((OUT_DELAY < 0) || (OUT_DELAY > OUT_DELAY_MAX)) begin : g_bad_delay
    $fatal(1, "vga_timing_gen: OUT_DELAY %0d outside 0..%0d", OUT_DELAY, OUT_DELAY_MAX);
  end

  localparam logic HS_POL = (HS_ACTIVE_HIGH != 0) ? POL_ACTIVE_HIGH : POL_ACTIVE_LOW;
  localparam logic VS_POL = (VS_ACTIVE_HIGH != 0) ? POL_ACTIVE_HIGH : POL_ACTIVE_LOW;

  // Stage word layout: {h_sync, v_sync, video_enable, line_start,
  // frame_start, x_idx, y_idx}, with syncs already at pin polarity.
  localparam int SW = 5 + 2 * CNT_W;
  localparam logic [SW-1:0] RST_VEC = {~HS_POL, ~VS_POL, 3'b000, {(2 * CNT_W){1'b0}}};

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_carry, v_carry_unused;
  logic             h_sync_act, v_sync_act;
  logic             h_act, v_act;
  logic             h_first, v_first;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .adv_i    (pix_ce),
    .cnt_o    (h_cnt),
    .carry_o  (h_carry),
    .sync_o   (h_sync_act),
    .active_o (h_act),
    .first_o  (h_first)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .adv_i    (h_carry),
    .cnt_o    (v_cnt),
    .carry_o  (v_carry_unused),
    .sync_o   (v_sync_act),
    .active_o (v_act),
    .first_o  (v_first)
  );

  logic [SW-1:0] pipe_q [OUT_DELAY+1];
  logic [SW-1:0] pipe_d [OUT_DELAY+1];

  // Stage 0 captures the decode of the current counter state; later
  // stages shift the previous stage along.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = {sync_level(h_sync_act, HS_POL),
                 sync_level(v_sync_act, VS_POL),
                 h_act & v_act,
                 h_first,
                 h_first & v_first,
                 h_cnt,
                 v_cnt};
    for (int i = 1; i <= OUT_DELAY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Output pipeline: cleared at once by reset, frozen while pix_ce is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= OUT_DELAY; i++) begin
        pipe_q[i] <= RST_VEC;
      end
    end else if (pix_ce) begin
      pipe_q <= pipe_d;
    end
  end

  assign {h_sync, v_sync, video_enable, line_start, frame_start, x_idx, y_idx} = pipe_q[OUT_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 14x7 raster. Three instances share
// clock, reset and pix_ce: A (OUT_DELAY 0, active-low syncs), B (OUT_DELAY 3)
// and C (active-high syncs). The reference model derives every output from
// the number of pix_ce samples seen since reset release.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 14
  localparam int VT = VA + VF + VS + VB;  // 7
  localparam int W  = 12;

  typedef struct packed {
    logic         hs;
    logic         vs;
    logic         ve;
    logic         ls;
    logic         fs;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  logic pix_ce;

  logic         a_hs, a_vs, a_ve, a_ls, a_fs;
  logic [W-1:0] a_x, a_y;
  logic         b_hs, b_vs, b_ve, b_ls, b_fs;
  logic [W-1:0] b_x, b_y;
  logic         c_hs, c_vs, c_ve, c_ls, c_fs;
  logic [W-1:0] c_x, c_y;
  out_t         a_o, b_o, c_o;

  assign a_o = {a_hs, a_vs, a_ve, a_ls, a_fs, a_x, a_y};
  assign b_o = {b_hs, b_vs, b_ve, b_ls, b_fs, b_x, b_y};
  assign c_o = {c_hs, c_vs, c_ve, c_ls, c_fs, c_x, c_y};

  int   checks   = 0;
  int   failures = 0;
  int   ce_cnt   = 0;
  out_t exp_q[$];

  int   ve_cnt, fs_cnt, vs_low, cyc, last_fall, first_rise, second_rise;
  logic prev_hs, prev_fs;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_ACTIVE_HIGH(0), .VS_ACTIVE_HIGH(0), .CNT_W(W), .OUT_DELAY(0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .h_sync(a_hs), .v_sync(a_vs), .video_enable(a_ve),
    .x_idx(a_x), .y_idx(a_y), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_ACTIVE_HIGH(0), .VS_ACTIVE_HIGH(0), .CNT_W(W), .OUT_DELAY(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .h_sync(b_hs), .v_sync(b_vs), .video_enable(b_ve),
    .x_idx(b_x), .y_idx(b_y), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_ACTIVE_HIGH(1), .VS_ACTIVE_HIGH(1), .CNT_W(W), .OUT_DELAY(0)
  ) u_dut_c (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .h_sync(c_hs), .v_sync(c_vs), .video_enable(c_ve),
    .x_idx(c_x), .y_idx(c_y), .line_start(c_ls), .frame_start(c_fs)
  );

  // ---------------- reference model ----------------
  // Output after n pix_ce samples with dly extra stages: raster position
  // p = n-1-dly in row-major order, reset values while p is negative.
  function automatic out_t model(input int n, input int dly, input logic hi);
    out_t o;
    int   p, x, y;
    p    = n - 1 - dly;
    o.hs = ~hi;
    o.vs = ~hi;
    o.ve = 1'b0;
    o.ls = 1'b0;
    o.fs = 1'b0;
    o.x  = '0;
    o.y  = '0;
    if (p >= 0) begin
      x    = p % HT;
      y    = (p / HT) % VT;
      o.hs = (x >= HA + HF && x < HA + HF + HS) ? hi : ~hi;
      o.vs = (y >= VA + VF && y < VA + VF + VS) ? hi : ~hi;
      o.ve = (x < HA) && (y < VA);
      o.ls = (x == 0);
      o.fs = (x == 0) && (y == 0);
      o.x  = W'(x);
      o.y  = W'(y);
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input out_t obs, input out_t exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("dut_a", a_o, model(ce_cnt, 0, 1'b0));
    chk("dut_b", b_o, model(ce_cnt, 3, 1'b0));
    chk("dut_c", c_o, model(ce_cnt, 0, 1'b1));
  endtask

  // ---------------- driver ----------------
  // Drive pix_ce, let one rising edge pass, then check on the falling edge.
  task automatic step(input logic ce);
    pix_ce = ce;
    @(posedge clk);
    if (ce && !reset) ce_cnt++;
    @(negedge clk);
    check_all();
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    reset  = 1'b1;
    ce_cnt = 0;
    #1;
    check_all();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset  = 1'b1;
    pix_ce = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    chk_int("reset_c_hsync_level", int'(c_hs), 0);
    chk_int("reset_c_vsync_level", int'(c_vs), 0);
    chk_int("reset_a_hsync_level", int'(a_hs), 1);
    step(1'b1);  // pix_ce during reset must not advance anything
    step(1'b1);
    reset = 1'b0;

    // Two full frames at pix_ce=1: window counts, periods, OUT_DELAY shift.
    exp_q.delete();
    prev_hs   = a_hs;
    cyc       = 0;
    last_fall = -1;
    for (int f = 0; f < 2; f++) begin
      ve_cnt = 0;
      fs_cnt = 0;
      vs_low = 0;
      for (int k = 0; k < HT * VT; k++) begin
        step(1'b1);
        cyc++;
        if (a_ve) ve_cnt++;
        if (a_fs) fs_cnt++;
        if (!a_vs) vs_low++;
        if (prev_hs && !a_hs) begin
          if (last_fall >= 0) chk_int("hsync_period", cyc - last_fall, HT);
          last_fall = cyc;
        end
        prev_hs = a_hs;
        exp_q.push_back(a_o);
        if (exp_q.size() == 4) chk("delay3_shift", b_o, exp_q.pop_front());
      end
      chk_int("video_enable_per_frame", ve_cnt, HA * VA);
      chk_int("frame_start_per_frame", fs_cnt, 1);
      chk_int("vsync_low_per_frame", vs_low, HT * VS);
    end

    // pix_ce alternating 1,0: frame stretches to twice its clock length.
    prev_fs     = a_fs;
    first_rise  = -1;
    second_rise = -1;
    for (int k = 0; k < 2 * HT * VT + 8; k++) begin
      step((k % 2) == 0);
      if (!prev_fs && a_fs) begin
        if (first_rise < 0) first_rise = k;
        else if (second_rise < 0) second_rise = k;
      end
      prev_fs = a_fs;
    end
    chk_int("frame_len_toggle", second_rise - first_rise, 2 * HT * VT);

    // Reset mid-frame at x=6, y=2, held for 3 clocks.
    async_reset();
    step(1'b1);
    reset = 1'b0;
    repeat (2 * HT + 6 + 1) step(1'b1);
    chk_int("pre_reset_x", int'(a_x), 6);
    chk_int("pre_reset_y", int'(a_y), 2);
    async_reset();
    repeat (3) step(1'($urandom_range(0, 1)));
    reset = 1'b0;
    step(1'b1);
    chk_int("frame_start_after_release", int'(a_fs), 1);
    chk_int("x_after_release", int'(a_x), 0);

    // Random pix_ce density with occasional reset pulses.
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
        repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)));
        reset = 1'b0;
      end
      step($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1920, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 88, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 44, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 148, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 1080, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 4, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 5, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 36, vertical back porch in lines.
REQ-009 SHALL have parameter HS_ACTIVE_HIGH, default 0, hsync polarity (0 = active-low).
REQ-010 SHALL have parameter VS_ACTIVE_HIGH, default 0, vsync polarity (0 = active-low).
REQ-011 SHALL have parameter CNT_W, default 12, counter and index width.
REQ-012 SHALL have parameter OUT_DELAY, default 0, range 0..7, extra output pipeline stages for downstream pixel-fetch latency.
REQ-013 SHALL have ports: clk input 1, pixel clock; reset input 1, asynchronous active-high reset; pix_ce input 1, pixel advance enable; h_sync output 1; v_sync output 1; video_enable output 1, pixel visible; x_idx output CNT_W, horizontal counter; y_idx output CNT_W, vertical counter; line_start output 1; frame_start output 1.

Function
REQ-014 Horizontal counter SHALL run 0..H_TOT-1 (H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP), advancing only on cycles with pix_ce=1, wrapping to 0.
REQ-015 Vertical counter SHALL advance by one, on the same pix_ce cycle the horizontal counter wraps, over 0..V_TOT-1 (V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP), wrapping to 0.
REQ-016 Sync SHALL be active when h counter is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync when v counter is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; each driven at its polarity parameter.
REQ-017 video_enable SHALL be 1 iff h counter < H_ACTIVE and v counter < V_ACTIVE.
REQ-018 x_idx/y_idx SHALL equal the raw counter values, including blanking.
REQ-019 line_start SHALL be 1 for the output sample where h=0; frame_start 1 where h=0 and v=0.
REQ-020 All outputs SHALL be registered, updating only on pix_ce=1, with latency 1+OUT_DELAY pix_ce-qualified samples after the counter state; all outputs mutually aligned.
REQ-021 With pix_ce=0 counters and all pipeline stages SHALL hold.
REQ-022 Counter arithmetic SHALL be CNT_W bits; H_TOT and V_TOT must be <= 2^CNT_W (elaboration check, fatal otherwise).

Reset
REQ-023 On reset: counters 0, all pipeline stages cleared; h_sync/v_sync at inactive level, video_enable 0, x_idx 0, y_idx 0, line_start 0, frame_start 0.
REQ-024 Reset asserted mid-line SHALL take effect immediately; after release, the first pix_ce sample SHALL present h=0, v=0 (frame_start=1) after the REQ-020 latency.

Structure
REQ-025 Polarity encodings and the OUT_DELAY maximum SHALL reside in shared package vga_timing_pkg.
REQ-026 One sub-module, timing_axis (counter + sync/active window decode, parametrised by active/fp/sync/bp), SHALL be instantiated for horizontal and vertical.

Verification
REQ-027 Small geometry H 8/2/2/2, V 4/1/1/1, pix_ce=1, OUT_DELAY=0 -> h_sync low on x 10..11, period 14 clk; v_sync low during y=5, frame 98 clk.
REQ-028 Same geometry, 2 full frames -> video_enable high exactly 32 clk per frame; frame_start once per 98 clk with x=0, y=0.
REQ-029 pix_ce toggled 1,0 repeatedly -> every output changes only on pix_ce=1 cycles; frame length 196 clk.
REQ-030 OUT_DELAY=3 vs OUT_DELAY=0 -> identical output sequences shifted by exactly 3 clk.
REQ-031 HS_ACTIVE_HIGH=1, VS_ACTIVE_HIGH=1 -> syncs inverted; reset value of both 0.
REQ-032 Reset asserted at x=6,y=2 for 3 clk -> outputs at reset values at once; after release, frame_start on first sample.
